// File: rtl/yolo_fp32_pkg.sv
// ---------------------------------------------------------------------------
// yolo_fp32_pkg
//
// Shared FP32 helpers for the pooling datapath.
//   FP32_WIDTH     : width of an IEEE-754 single-precision word
//   FP32_POS_ZERO  : +0.0 encoding, used as reset value and ReLU clamp value
//   FP32_SIGN_MASK : sign-bit mask
//   fp32_key()     : maps an FP32 word to an unsigned key whose integer
//                    ordering matches the floating-point ordering
//                    (-0.0 orders just below +0.0; NaN is not handled)
// ---------------------------------------------------------------------------
package yolo_fp32_pkg;

    localparam int FP32_WIDTH = 32;

    localparam logic [FP32_WIDTH-1:0] FP32_POS_ZERO  = 32'h0000_0000;
    localparam logic [FP32_WIDTH-1:0] FP32_SIGN_MASK = 32'h8000_0000;

    // Negative values: inverting every bit reverses the magnitude order and
    // puts them below all positives. Positive values: setting the sign bit
    // lifts them above every negative key while keeping magnitude order.
    function automatic logic [FP32_WIDTH-1:0] fp32_key(input logic [FP32_WIDTH-1:0] x);
        if (x[FP32_WIDTH-1]) begin
            return ~x;
        end
        return x | FP32_SIGN_MASK;
    endfunction

endpackage

// File: rtl/fp32_max2.sv
// ---------------------------------------------------------------------------
// fp32_max2
//
// Purely combinational two-input FP32 maximum.
//   a : earlier operand (wins on equal keys)
//   b : later operand
//   y : max(a, b) by the fp32_key ordering
// ---------------------------------------------------------------------------
module fp32_max2
    import yolo_fp32_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic [FP32_WIDTH-1:0] y
);

    logic [FP32_WIDTH-1:0] key_a;
    logic [FP32_WIDTH-1:0] key_b;

    always_comb begin
        key_a = fp32_key(a);
        key_b = fp32_key(b);
        // Strict compare: b must be larger to displace the earlier operand.
        y = (key_b > key_a) ? b : a;
    end

endmodule

// File: rtl/layer_4_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// layer_4_maxpool_2x2
//
// Streaming 2x2 / stride-2 max pool over a single-channel FP32 raster of
// IMG_SIZE x IMG_SIZE pixels (row-major, one pixel per valid_in beat).
// Even rows store horizontal pair maxima in a half-row line buffer; odd
// rows combine their horizontal pair with the stored value and emit one
// pooled pixel, registered, one cycle after the window's last beat.
//
// Parameters
//   IMG_SIZE   : input width/height, even and >= 2
//   DATA_WIDTH : pixel width, only 32 (FP32) is supported
//
// Ports
//   Clk       in  : rising-edge clock
//   Rst       in  : asynchronous active-low reset
//   data_in   in  : input pixel
//   valid_in  in  : data_in valid this cycle (no backpressure)
//   data_out  out : pooled pixel, holds while valid_out is low
//   valid_out out : one-cycle strobe per pooled pixel
//   frame_end out : with valid_out on the last pooled pixel of a frame
//
// Build option
//   MAXPOOL_RELU_EN : when defined, any pooled result with the sign bit set
//                     (including -0.0) is clamped to +0.0 before output.
// ---------------------------------------------------------------------------
module layer_4_maxpool_2x2
    import yolo_fp32_pkg::*;
#(
    parameter int IMG_SIZE   = 104,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_end
);

    localparam int CW       = $clog2(IMG_SIZE);
    localparam int LB_DEPTH = IMG_SIZE / 2;
    localparam int HW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic                  col_last;
    logic                  row_last;
    logic [HW-1:0]         half;

    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] line_buf [LB_DEPTH];
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] v_max;
    logic [DATA_WIDTH-1:0] pooled;

    logic                  lb_wr_en;
    logic                  out_en;

    assign col_last = (col == LAST_IDX);
    assign row_last = (row == LAST_IDX);
    assign half     = HW'(col >> 1);

    // Even-row odd-column beats write; odd-row odd-column beats read.
    // Row parity keeps the two apart, so the read never sees a same-cycle write.
    assign lb_wr_en = valid_in && !row[0] && col[0];
    assign out_en   = valid_in &&  row[0] && col[0];

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Left pixel of the current horizontal pair
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hmax <= FP32_POS_ZERO;
        end else if (valid_in && !col[0]) begin
            hmax <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Half-row buffer of even-row pair maxima. Not reset: every entry is
    // rewritten during an even row before the following odd row reads it.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (lb_wr_en) begin
            line_buf[half] <= h_max;
        end
    end

    assign lb_rd = line_buf[half];

    // ------------------------------------------------------------------
    // Compare tree: horizontal pair first, then against the upper row.
    // Operand order follows arrival order so ties keep the earlier pixel.
    // ------------------------------------------------------------------
    fp32_max2 u_max_h (
        .a (hmax),
        .b (data_in),
        .y (h_max)
    );

    fp32_max2 u_max_v (
        .a (lb_rd),
        .b (h_max),
        .y (v_max)
    );

    always_comb begin
        pooled = v_max;
`ifdef MAXPOOL_RELU_EN
        if (v_max[DATA_WIDTH-1]) begin
            pooled = FP32_POS_ZERO;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_out  <= FP32_POS_ZERO;
            valid_out <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_end <= 1'b0;
            if (out_en) begin
                data_out  <= pooled;
                valid_out <= 1'b1;
                frame_end <= row_last && col_last;
            end
        end
    end

endmodule

// File: tb/tb_layer_4_maxpool_2x2.sv
module tb_layer_4_maxpool_2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_4, rst_104;
    logic [31:0] d4, d104, q4, q104;
    logic        v4, v104, qv4, qv104, fe4, fe104;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last4   = 32'h0;
    logic [31:0] last104 = 32'h0;

    logic [31:0] frame104 [104][104];

    logic [31:0] ramp  [16];
    logic [31:0] neg   [16];
    logic [31:0] zt    [16];
    logic [31:0] e_ramp[4];
    logic [31:0] e_neg [4];
    logic [31:0] e_zt  [4];

    layer_4_maxpool_2x2 #(.IMG_SIZE(4), .DATA_WIDTH(32)) dut4 (
        .Clk       (clk),
        .Rst       (rst_4),
        .data_in   (d4),
        .valid_in  (v4),
        .data_out  (q4),
        .valid_out (qv4),
        .frame_end (fe4)
    );

    layer_4_maxpool_2x2 #(.IMG_SIZE(104), .DATA_WIDTH(32)) dut104 (
        .Clk       (clk),
        .Rst       (rst_104),
        .data_in   (d104),
        .valid_in  (v104),
        .data_out  (q104),
        .valid_out (qv104),
        .frame_end (fe104)
    );

    // Independent FP32 ordering: true when a is strictly above b.
    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a > b;
        return a < b;
    endfunction

    function automatic logic [31:0] pool4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        logic [31:0] m;
        m = a;
        if (fp_gt(b, m)) m = b;
        if (fp_gt(c, m)) m = c;
        if (fp_gt(d, m)) m = d;
`ifdef MAXPOOL_RELU_EN
        if (m[31]) m = 32'h0;
`endif
        return m;
    endfunction

    function automatic logic [31:0] rand_pix();
        logic [22:0] man;
        logic [7:0]  ex;
        logic        s;
        s   = 1'($urandom_range(0, 1));
        ex  = 8'($urandom_range(125, 129));
        man = 23'($urandom_range(0, 15));
        man = man << 19;
        if ($urandom_range(0, 15) == 0) return {s, 31'h0};
        return {s, ex, man};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_4 = 1'b1; rst_104 = 1'b1;
        v4 = 1'b0; v104 = 1'b0; d4 = '0; d104 = '0;
        #2;
        rst_4 = 1'b0; rst_104 = 1'b0;
        #1;
        checks++;
        if ({qv4, fe4, q4} !== 34'h0) begin
            failures++;
            $display("FAIL reset4_async got v=%0b fe=%0b d=%h exp all zero", qv4, fe4, q4);
        end
        checks++;
        if ({qv104, fe104, q104} !== 34'h0) begin
            failures++;
            $display("FAIL reset104_async got v=%0b fe=%0b d=%h exp all zero", qv104, fe104, q104);
        end
        repeat (2) tick();
        rst_4 = 1'b1; rst_104 = 1'b1;
        tick();
        checks++;
        if ({qv4, fe4, q4} !== 34'h0) begin
            failures++;
            $display("FAIL reset4_idle got v=%0b fe=%0b d=%h exp all zero", qv4, fe4, q4);
        end
        checks++;
        if ({qv104, fe104, q104} !== 34'h0) begin
            failures++;
            $display("FAIL reset104_idle got v=%0b fe=%0b d=%h exp all zero", qv104, fe104, q104);
        end
        last4 = 32'h0; last104 = 32'h0;
    endtask

    // One 4x4 frame with random idle gaps; checks every cycle.
    task automatic test_frame4x4(input string name, input logic [31:0] pix[16],
                                 input logic [31:0] expv[4], input int max_gap);
        int nobs = 0;
        int nout = 0;
        logic ev, ef;
        logic [31:0] ed;
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                v4 = 1'b0;
                tick();
                if (qv4) nobs++;
                checks++;
                if ({qv4, fe4, q4} !== {1'b0, 1'b0, last4}) begin
                    failures++;
                    $display("FAIL %s_idle beat %0d got v=%0b fe=%0b d=%h exp v=0 fe=0 d=%h",
                             name, i, qv4, fe4, q4, last4);
                end
            end
            v4 = 1'b1; d4 = pix[i];
            tick();
            v4 = 1'b0;
            if (qv4) nobs++;
            ev = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
            ef = (i == 15);
            ed = ev ? expv[nout] : last4;
            checks++;
            if ({qv4, fe4, q4} !== {ev, ef, ed}) begin
                failures++;
                $display("FAIL %s_beat %0d got v=%0b fe=%0b d=%h exp v=%0b fe=%0b d=%h",
                         name, i, qv4, fe4, q4, ev, ef, ed);
            end
            if (ev) begin
                last4 = expv[nout];
                nout++;
            end
        end
        tick();
        if (qv4) nobs++;
        checks++;
        if (nobs !== 4) begin
            failures++;
            $display("FAIL %s_strobes got %0d exp 4", name, nobs);
        end
    endtask

    task automatic test_back_to_back();
        int nobs = 0;
        int nfe  = 0;
        logic ev, ef;
        logic [31:0] ed;
        for (int i = 0; i < 32; i++) begin
            int k;
            k = i % 16;
            v4 = 1'b1;
            d4 = (i < 16) ? ramp[k] : neg[k];
            tick();
            if (qv4) nobs++;
            if (fe4) nfe++;
            ev = ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1);
            ef = (k == 15);
            if (ev) ed = (i < 16) ? e_ramp[k / 8 * 2 + (k % 4) / 2] : e_neg[k / 8 * 2 + (k % 4) / 2];
            else    ed = last4;
            checks++;
            if ({qv4, fe4, q4} !== {ev, ef, ed}) begin
                failures++;
                $display("FAIL b2b_beat %0d got v=%0b fe=%0b d=%h exp v=%0b fe=%0b d=%h",
                         i, qv4, fe4, q4, ev, ef, ed);
            end
            if (ev) last4 = ed;
        end
        v4 = 1'b0;
        tick();
        if (qv4) nobs++;
        checks++;
        if (nobs !== 8 || nfe !== 2) begin
            failures++;
            $display("FAIL b2b_counts got strobes=%0d fe=%0d exp strobes=8 fe=2", nobs, nfe);
        end
    endtask

    // Streams beats 0..nbeats-1 of frame104; checks each cycle against pool4.
    task automatic stream_104(input string name, input int max_gap, input int nbeats,
                              output int nstrobe, output int nfe);
        logic ev, ef;
        logic [31:0] ed;
        nstrobe = 0;
        nfe     = 0;
        for (int i = 0; i < nbeats; i++) begin
            int r, c, gap;
            r = i / 104;
            c = i % 104;
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                v104 = 1'b0;
                tick();
                if (qv104) nstrobe++;
                if (fe104) nfe++;
                checks++;
                if ({qv104, fe104, q104} !== {1'b0, 1'b0, last104}) begin
                    failures++;
                    $display("FAIL %s_idle r=%0d c=%0d got v=%0b fe=%0b d=%h exp v=0 fe=0 d=%h",
                             name, r, c, qv104, fe104, q104, last104);
                end
            end
            v104 = 1'b1;
            d104 = frame104[r][c];
            tick();
            v104 = 1'b0;
            if (qv104) nstrobe++;
            if (fe104) nfe++;
            ev = (r % 2 == 1) && (c % 2 == 1);
            ef = (r == 103) && (c == 103);
            if (ev) ed = pool4(frame104[r-1][c-1], frame104[r-1][c], frame104[r][c-1], frame104[r][c]);
            else    ed = last104;
            checks++;
            if ({qv104, fe104, q104} !== {ev, ef, ed}) begin
                failures++;
                $display("FAIL %s_beat r=%0d c=%0d got v=%0b fe=%0b d=%h exp v=%0b fe=%0b d=%h",
                         name, r, c, qv104, fe104, q104, ev, ef, ed);
            end
            if (ev) last104 = ed;
        end
    endtask

    task automatic fill_frame104();
        for (int r = 0; r < 104; r++)
            for (int c = 0; c < 104; c++)
                frame104[r][c] = rand_pix();
    endtask

    task automatic test_random_gaps_104();
        int ns, nf;
        fill_frame104();
        stream_104("rand_gaps", 5, 104 * 104, ns, nf);
        tick();
        if (qv104) ns++;
        checks++;
        if (ns !== 2704) begin
            failures++;
            $display("FAIL rand_gaps_count got %0d exp 2704", ns);
        end
        checks++;
        if (nf !== 1) begin
            failures++;
            $display("FAIL rand_gaps_frame_end got %0d exp 1", nf);
        end
    endtask

    task automatic test_reset_midframe_104();
        int ns, nf;
        fill_frame104();
        stream_104("pre_rst", 0, 3 * 104 + 5, ns, nf);
        checks++;
        if (ns !== 54) begin
            failures++;
            $display("FAIL pre_rst_count got %0d exp 54", ns);
        end
        rst_104 = 1'b0;
        #2;
        checks++;
        if ({qv104, fe104, q104} !== 34'h0) begin
            failures++;
            $display("FAIL midframe_rst_clear got v=%0b fe=%0b d=%h exp all zero", qv104, fe104, q104);
        end
        last104 = 32'h0;
        tick();
        rst_104 = 1'b1;
        tick();
        fill_frame104();
        stream_104("post_rst", 1, 104 * 104, ns, nf);
        tick();
        if (qv104) ns++;
        checks++;
        if (ns !== 2704 || nf !== 1) begin
            failures++;
            $display("FAIL post_rst_counts got strobes=%0d fe=%0d exp strobes=2704 fe=1", ns, nf);
        end
    endtask

    initial begin
        ramp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        for (int i = 0; i < 16; i++) neg[i] = ramp[i] | 32'h80000000;
        zt = '{32'h80000000, 32'h00000000, 32'h40400000, 32'h40400000,
               32'h80000000, 32'h80000000, 32'h40400000, 32'h40400000,
               32'h80000000, 32'h80000000, 32'hBF800000, 32'h3F800000,
               32'h80000000, 32'h80000000, 32'hC0000000, 32'h3F000000};
        e_ramp = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
`ifdef MAXPOOL_RELU_EN
        e_neg = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        e_zt  = '{32'h00000000, 32'h40400000, 32'h00000000, 32'h3F800000};
`else
        e_neg = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
        e_zt  = '{32'h00000000, 32'h40400000, 32'h80000000, 32'h3F800000};
`endif
        test_reset();
        test_frame4x4("ramp", ramp, e_ramp, 0);
        test_frame4x4("negative", neg, e_neg, 3);
        test_frame4x4("zero_ties", zt, e_zt, 2);
        test_back_to_back();
        test_random_gaps_104();
        test_reset_midframe_104();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer_4_maxpool_2x2.md
# layer_4_maxpool_2x2

Streaming 2x2, stride-2 max-pooling stage that consumes the single-channel FP32 raster stream produced by a layer-4 feature-map block and emits the pooled map for the next layer. It accepts one pixel per `valid_in` cycle in row-major order and buffers one half-row of partial maxima. It emits one pooled pixel per completed 2x2 window, so a 104x104 input produces a 52x52 output.

## Interface
- `IMG_SIZE`, 104: input width and height in pixels; must be even and at least 2.
- `DATA_WIDTH`, 32: pixel width; IEEE-754 single precision; only 32 is supported.
- `Clk`  in  1: single clock; all logic is rising-edge.
- `Rst`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_WIDTH: input pixel.
- `valid_in`  in  1: `data_in` is valid this cycle; no backpressure exists.
- `data_out`  out  DATA_WIDTH: pooled pixel; reset value `32'h00000000`.
- `valid_out`  out  1: one-cycle strobe per pooled pixel; reset value 0.
- `frame_end`  out  1: high together with `valid_out` for the last pooled pixel of a frame; reset value 0.

## Operation
- Counters:
  - `col` runs 0..IMG_SIZE-1 and `row` runs 0..IMG_SIZE-1.
  - Both advance only on `valid_in`.
  - `col` wraps to 0 after IMG_SIZE-1 and increments `row`.
  - `row` wraps to 0 after IMG_SIZE-1, so the next frame starts immediately.
- FP32 compare:
  - Each operand is mapped to an ordering key: negative → `~x`; otherwise `x | 32'h80000000`.
  - The larger key, as an unsigned compare, wins.
  - On equal keys the earlier operand wins.
  - -0.0 orders below +0.0.
  - NaN inputs are unsupported; the result is defined by the key rule only.
- Even row:
  - Even `col`: register the pixel as `hmax`.
  - Odd `col`: write max(`hmax`, `data_in`) into `line_buf[col>>1]`.
  - `line_buf` has depth IMG_SIZE/2.
- Odd row:
  - Even `col`: register the pixel as `hmax`.
  - Odd `col`: compute max(`hmax`, `data_in`, `line_buf[col>>1]`), register it into `data_out` and pulse `valid_out`.
- `frame_end` pulses when the output comes from `row`=IMG_SIZE-1, `col`=IMG_SIZE-1.
- `valid_in` gaps of any length are allowed; all state holds and there are no timeouts.
- `data_out` holds its last value while `valid_out` is low.

## Timing
- Latency: `valid_out` rises exactly 1 cycle after the `valid_in` beat carrying the bottom-right pixel of a window.
- Throughput: 1 input per cycle sustained; at most 1 output per 2 input beats.
- `line_buf` read (odd row) and write (even row) never coincide. The read is combinational from registers, or from a synchronous RAM addressed one beat early. Either way, the 1-cycle latency is preserved.
- Reset mid-frame:
  - Counters, `hmax`, `valid_out`, `frame_end` and `data_out` clear asynchronously.
  - The next `valid_in` is treated as pixel (0,0).
  - `line_buf` is not cleared; stale contents are always overwritten before they are read.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle in which `frame_end` of frame N is high.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: a pooled result with sign bit 1 (including -0.0) is replaced by `32'h00000000` before it is registered into `data_out`. This is a fused ReLU clamp with no extra latency.
  - Undefined: the raw pooled maximum is output.

## Structure
- Package `yolo_fp32_pkg`: `FP32_POS_ZERO`, the FP32 width constant, and an `fp32_key` function implementing the ordering-key transform.
- Sub-module `fp32_max2`: purely combinational two-input max using `fp32_key`, with the earlier-operand tie rule.
  - Two instances form the horizontal and vertical compares.
  - Three instances when the odd-row three-way max is split.

## Test plan
- IMG_SIZE=4, frame of pixels 1.0..16.0 (`3F800000`…`41800000`) → outputs 6.0, 8.0, 14.0, 16.0; `frame_end` only with 16.0; 4 strobes total.
- All-negative frame (-1.0 … -16.0) → outputs -1.0, -3.0, -9.0, -11.0.
  - With `MAXPOOL_RELU_EN`: four outputs of `00000000`.
- Window {-0.0, +0.0, -0.0, -0.0} → `00000000`. Window of four equal values `40400000` → `40400000`.
- Random `valid_in` gaps (0–5 idle cycles) on a random 104x104 frame → 2704 outputs bit-identical to a golden model; each `valid_out` exactly 1 cycle after its completing input beat.
- `Rst` asserted at row 3, col 5 of a 104 frame, then a full frame streamed → exactly 2704 outputs matching the golden model; no output before the first completed window.
- Two back-to-back 4x4 frames with no gap → 8 strobes, with `frame_end` on the 4th and 8th.
